// File: rtl/chacha_aead_framer_if.sv
// Stream bundle for the ChaCha20-Poly1305 AEAD framer: AAD/payload inputs,
// padded AAD/payload outputs and the Poly1305 length block output.
interface chacha_aead_framer_if;
   logic         s_aad_valid;
   logic [127:0] s_aad_data;
   logic [15:0]  s_aad_keep;
   logic         s_aad_last;
   logic         s_aad_ready;

   logic         s_pld_valid;
   logic [127:0] s_pld_data;
   logic [15:0]  s_pld_keep;
   logic         s_pld_last;
   logic         s_pld_ready;

   logic         aad_valid;
   logic [127:0] aad_data;
   logic [15:0]  aad_keep;
   logic         aad_ready;

   logic         pld_valid;
   logic [127:0] pld_data;
   logic [15:0]  pld_keep;
   logic         pld_ready;

   logic         len_valid;
   logic [127:0] len_block;
   logic         len_ready;

   // Framer side: sinks the input streams, sources the padded streams.
   modport master (
      input  s_aad_valid, s_aad_data, s_aad_keep, s_aad_last,
      output s_aad_ready,
      input  s_pld_valid, s_pld_data, s_pld_keep, s_pld_last,
      output s_pld_ready,
      output aad_valid, aad_data, aad_keep,
      input  aad_ready,
      output pld_valid, pld_data, pld_keep,
      input  pld_ready,
      output len_valid, len_block,
      input  len_ready
   );

   modport slave (
      output s_aad_valid, s_aad_data, s_aad_keep, s_aad_last,
      input  s_aad_ready,
      output s_pld_valid, s_pld_data, s_pld_keep, s_pld_last,
      input  s_pld_ready,
      input  aad_valid, aad_data, aad_keep,
      output aad_ready,
      input  pld_valid, pld_data, pld_keep,
      output pld_ready,
      input  len_valid, len_block,
      output len_ready
   );
endinterface

// File: rtl/chacha_aead_framer.sv
// Frames AAD and ciphertext for Poly1305: pads each stream to 16-byte blocks,
// counts bytes, then emits the {pld_len, aad_len} length block.
module chacha_aead_framer #(
   parameter int LEN_W      = 64,
   parameter bit ERR_ON_OVF = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  aad_skip,
   input  logic                  pld_skip,
   chacha_aead_framer_if.master  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [LEN_W-1:0]      aad_bytes,
   output logic [LEN_W-1:0]      pld_bytes
);

   typedef enum logic [1:0] {ST_IDLE, ST_AAD, ST_PLD, ST_LEN} state_t;

   state_t             state_q, state_d;
   logic               aad_valid_q, aad_valid_d;
   logic [127:0]       aad_data_q, aad_data_d;
   logic               pld_valid_q, pld_valid_d;
   logic [127:0]       pld_data_q, pld_data_d;
   logic               len_valid_q, len_valid_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               pld_skip_q, pld_skip_d;
   logic [LEN_W-1:0]   aad_cnt_q, aad_cnt_d;
   logic [LEN_W-1:0]   pld_cnt_q, pld_cnt_d;

   logic               s_aad_rdy, s_pld_rdy;
   logic               aad_fire, pld_fire;
   logic [LEN_W:0]     aad_sum, pld_sum;
   logic               aad_bad, pld_bad;

   function automatic logic [4:0] popcount16(input logic [15:0] k);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, k[i]};
      return c;
   endfunction

   // Non-last beats must be full; a last beat must be a 1..16 byte prefix.
   function automatic logic keep_ok(input logic [15:0] k, input logic last);
      logic [15:0] k_inc;
      logic        ok;
      k_inc = k + 16'd1;
      if (last) ok = (k != 16'd0) && ((k & k_inc) == 16'd0);
      else      ok = (k == 16'hFFFF);
      return ok;
   endfunction

   function automatic logic [127:0] pad16(input logic [127:0] d, input logic [15:0] k);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'd0;
      return o;
   endfunction

   assign s_aad_rdy = (state_q == ST_AAD) && (!aad_valid_q || bus.aad_ready);
   assign s_pld_rdy = (state_q == ST_PLD) && (!pld_valid_q || bus.pld_ready);
   assign aad_fire  = bus.s_aad_valid && s_aad_rdy;
   assign pld_fire  = bus.s_pld_valid && s_pld_rdy;

   // The extra top bit of each sum is the counter carry-out.
   assign aad_sum = {1'b0, aad_cnt_q} + {{(LEN_W-4){1'b0}}, popcount16(bus.s_aad_keep)};
   assign pld_sum = {1'b0, pld_cnt_q} + {{(LEN_W-4){1'b0}}, popcount16(bus.s_pld_keep)};
   assign aad_bad = !keep_ok(bus.s_aad_keep, bus.s_aad_last) || (ERR_ON_OVF && aad_sum[LEN_W]);
   assign pld_bad = !keep_ok(bus.s_pld_keep, bus.s_pld_last) || (ERR_ON_OVF && pld_sum[LEN_W]);

   always_comb begin
      state_d     = state_q;
      aad_valid_d = aad_valid_q && !bus.aad_ready;
      aad_data_d  = aad_data_q;
      pld_valid_d = pld_valid_q && !bus.pld_ready;
      pld_data_d  = pld_data_q;
      len_valid_d = len_valid_q;
      done_d      = 1'b0;
      err_d       = err_q;
      pld_skip_d  = pld_skip_q;
      aad_cnt_d   = aad_cnt_q;
      pld_cnt_d   = pld_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               aad_cnt_d  = '0;
               pld_cnt_d  = '0;
               pld_skip_d = pld_skip;
               if (!aad_skip)     state_d = ST_AAD;
               else if (!pld_skip) state_d = ST_PLD;
               else               state_d = ST_LEN;
            end
         end
         ST_AAD: begin
            if (aad_fire) begin
               if (aad_bad) begin
                  err_d       = 1'b1;
                  aad_valid_d = 1'b0;
                  pld_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  aad_valid_d = 1'b1;
                  aad_data_d  = pad16(bus.s_aad_data, bus.s_aad_keep);
                  aad_cnt_d   = aad_sum[LEN_W-1:0];
                  if (bus.s_aad_last) state_d = pld_skip_q ? ST_LEN : ST_PLD;
               end
            end
         end
         ST_PLD: begin
            if (pld_fire) begin
               if (pld_bad) begin
                  err_d       = 1'b1;
                  aad_valid_d = 1'b0;
                  pld_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  pld_valid_d = 1'b1;
                  pld_data_d  = pad16(bus.s_pld_data, bus.s_pld_keep);
                  pld_cnt_d   = pld_sum[LEN_W-1:0];
                  if (bus.s_pld_last) state_d = ST_LEN;
               end
            end
         end
         ST_LEN: begin
            // The length block waits until both padded streams have drained.
            if (len_valid_q && bus.len_ready) begin
               len_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
            end else if (!aad_valid_q && !pld_valid_q) begin
               len_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         aad_valid_q <= 1'b0;
         aad_data_q  <= '0;
         pld_valid_q <= 1'b0;
         pld_data_q  <= '0;
         len_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pld_skip_q  <= 1'b0;
         aad_cnt_q   <= '0;
         pld_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         aad_valid_q <= aad_valid_d;
         aad_data_q  <= aad_data_d;
         pld_valid_q <= pld_valid_d;
         pld_data_q  <= pld_data_d;
         len_valid_q <= len_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pld_skip_q  <= pld_skip_d;
         aad_cnt_q   <= aad_cnt_d;
         pld_cnt_q   <= pld_cnt_d;
      end
   end

   assign bus.s_aad_ready = s_aad_rdy;
   assign bus.s_pld_ready = s_pld_rdy;
   assign bus.aad_valid   = aad_valid_q;
   assign bus.aad_data    = aad_data_q;
   assign bus.aad_keep    = 16'hFFFF;
   assign bus.pld_valid   = pld_valid_q;
   assign bus.pld_data    = pld_data_q;
   assign bus.pld_keep    = 16'hFFFF;
   assign bus.len_valid   = len_valid_q;
   assign bus.len_block   = {64'(pld_cnt_q), 64'(aad_cnt_q)};

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign aad_bytes = aad_cnt_q;
   assign pld_bytes = pld_cnt_q;

endmodule

// File: tb/tb_chacha_aead_framer.sv
// Randomised self-checking bench for chacha_aead_framer against a byte-level
// message model (padded block queues and byte totals).
module tb_chacha_aead_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start, aad_skip, pld_skip;
   logic        busy, done, err;
   logic [63:0] aad_bytes, pld_bytes;

   logic        start_o1, start_o0, ovf_aad_skip, ovf_pld_skip;
   logic        busy_o1, done_o1, err_o1, busy_o0, done_o0, err_o0;
   logic [7:0]  aad_bytes_o1, pld_bytes_o1, aad_bytes_o0, pld_bytes_o0;

   int vec_count = 0;
   int miscompare_count = 0;

   logic [127:0] aad_beats[$];
   int           aad_lens[$];
   logic [127:0] pld_beats[$];
   int           pld_lens[$];

   chacha_aead_framer_if bus();
   chacha_aead_framer_if bus_o1();
   chacha_aead_framer_if bus_o0();

   chacha_aead_framer #(.LEN_W(64), .ERR_ON_OVF(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .aad_skip(aad_skip), .pld_skip(pld_skip),
      .bus(bus), .busy(busy), .done(done), .err(err),
      .aad_bytes(aad_bytes), .pld_bytes(pld_bytes)
   );

   chacha_aead_framer #(.LEN_W(8), .ERR_ON_OVF(1'b1)) dut_o1 (
      .clk(clk), .rst_n(rst_n), .start(start_o1), .aad_skip(ovf_aad_skip), .pld_skip(ovf_pld_skip),
      .bus(bus_o1), .busy(busy_o1), .done(done_o1), .err(err_o1),
      .aad_bytes(aad_bytes_o1), .pld_bytes(pld_bytes_o1)
   );

   chacha_aead_framer #(.LEN_W(8), .ERR_ON_OVF(1'b0)) dut_o0 (
      .clk(clk), .rst_n(rst_n), .start(start_o0), .aad_skip(ovf_aad_skip), .pld_skip(ovf_pld_skip),
      .bus(bus_o0), .busy(busy_o0), .done(done_o0), .err(err_o0),
      .aad_bytes(aad_bytes_o0), .pld_bytes(pld_bytes_o0)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [15:0] len_keep(input int n);
      logic [16:0] t;
      t = (17'd1 << n) - 17'd1;
      return t[15:0];
   endfunction

   // Reference padding: keep the first n bytes of the block, zero the rest.
   function automatic logic [127:0] model_pad(input logic [127:0] d, input int n);
      if (n >= 16) return d;
      return d & ((128'd1 << (8 * n)) - 128'd1);
   endfunction

   task automatic add_beats(input bit is_pld, input int nbeats, input int last_len);
      for (int b = 0; b < nbeats; b++) begin
         if (is_pld) begin
            pld_beats.push_back(rand128());
            pld_lens.push_back((b == nbeats - 1) ? last_len : 16);
         end else begin
            aad_beats.push_back(rand128());
            aad_lens.push_back((b == nbeats - 1) ? last_len : 16);
         end
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; aad_skip = 1'b0; pld_skip = 1'b0;
      bus.s_aad_valid = 1'b0; bus.s_aad_data = '0; bus.s_aad_keep = '0; bus.s_aad_last = 1'b0;
      bus.s_pld_valid = 1'b0; bus.s_pld_data = '0; bus.s_pld_keep = '0; bus.s_pld_last = 1'b0;
      bus.aad_ready = 1'b0; bus.pld_ready = 1'b0; bus.len_ready = 1'b0;
   endtask

   task automatic run_message(input string name, input bit a_skip, input bit p_skip,
                              input int stall, input bit noisy);
      logic [127:0]    exp_aad[$];
      logic [127:0]    exp_pld[$];
      logic [127:0]    e;
      logic [127:0]    exp_len;
      longint unsigned aad_tot = 0, pld_tot = 0;
      int              ai = 0, pi = 0, cyc = 0, a_st = 0, p_st = 0;
      bit              len_seen = 0;
      foreach (aad_lens[i]) aad_tot += aad_lens[i];
      foreach (pld_lens[i]) pld_tot += pld_lens[i];
      exp_len = {64'(pld_tot), 64'(aad_tot)};
      @(negedge clk);
      start = 1'b1; aad_skip = a_skip; pld_skip = p_skip;
      @(negedge clk);
      start = 1'b0;
      while (!len_seen && cyc < 3000) begin
         bus.s_aad_valid = (ai < aad_beats.size());
         if (ai < aad_beats.size()) begin
            bus.s_aad_data = aad_beats[ai];
            bus.s_aad_keep = len_keep(aad_lens[ai]);
            bus.s_aad_last = (ai == aad_beats.size() - 1);
         end
         bus.s_pld_valid = (pi < pld_beats.size());
         if (pi < pld_beats.size()) begin
            bus.s_pld_data = pld_beats[pi];
            bus.s_pld_keep = len_keep(pld_lens[pi]);
            bus.s_pld_last = (pi == pld_beats.size() - 1);
         end
         if (bus.aad_valid) a_st++;
         if (bus.pld_valid) p_st++;
         bus.aad_ready = (a_st > stall) && ($urandom_range(0, 3) != 0);
         bus.pld_ready = (p_st > stall) && ($urandom_range(0, 3) != 0);
         bus.len_ready = $urandom_range(0, 1);
         start = noisy && busy && ($urandom_range(0, 3) == 0);
         #1;
         if (bus.aad_valid && !bus.aad_ready) begin
            vec_count++;
            if (bus.s_aad_ready !== 1'b0) begin
               miscompare_count++;
               $display("[TB] FAIL %s aad_backpressure: s_aad_ready=%b expected 0", name, bus.s_aad_ready);
            end
         end
         if (bus.pld_valid && !bus.pld_ready) begin
            vec_count++;
            if (bus.s_pld_ready !== 1'b0) begin
               miscompare_count++;
               $display("[TB] FAIL %s pld_backpressure: s_pld_ready=%b expected 0", name, bus.s_pld_ready);
            end
         end
         if (bus.aad_valid && bus.aad_ready) begin
            vec_count++;
            if (exp_aad.size() == 0) begin
               miscompare_count++;
               $display("[TB] FAIL %s aad_spurious: got %h expected no beat", name, bus.aad_data);
            end else begin
               e = exp_aad.pop_front();
               if (bus.aad_data !== e || bus.aad_keep !== 16'hFFFF) begin
                  miscompare_count++;
                  $display("[TB] FAIL %s aad_out: got %h/%h expected %h/ffff", name, bus.aad_data, bus.aad_keep, e);
               end
            end
         end
         if (bus.pld_valid && bus.pld_ready) begin
            vec_count++;
            if (exp_pld.size() == 0) begin
               miscompare_count++;
               $display("[TB] FAIL %s pld_spurious: got %h expected no beat", name, bus.pld_data);
            end else begin
               e = exp_pld.pop_front();
               if (bus.pld_data !== e || bus.pld_keep !== 16'hFFFF) begin
                  miscompare_count++;
                  $display("[TB] FAIL %s pld_out: got %h/%h expected %h/ffff", name, bus.pld_data, bus.pld_keep, e);
               end
            end
         end
         if (bus.s_aad_valid && bus.s_aad_ready) begin
            exp_aad.push_back(model_pad(bus.s_aad_data, aad_lens[ai]));
            ai++;
         end
         if (bus.s_pld_valid && bus.s_pld_ready) begin
            exp_pld.push_back(model_pad(bus.s_pld_data, pld_lens[pi]));
            pi++;
         end
         if (done === 1'b1) begin
            vec_count++; miscompare_count++;
            $display("[TB] FAIL %s early_done: done=1 expected 0", name);
         end
         if (bus.len_valid && bus.len_ready) begin
            vec_count++;
            len_seen = 1;
            if (bus.len_block !== exp_len || exp_aad.size() != 0 || exp_pld.size() != 0 ||
                ai != aad_beats.size() || pi != pld_beats.size()) begin
               miscompare_count++;
               $display("[TB] FAIL %s len_block: got %h expected %h (pending aad %0d pld %0d)",
                        name, bus.len_block, exp_len, exp_aad.size(), exp_pld.size());
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (!len_seen) begin
         vec_count++; miscompare_count++;
         $display("[TB] FAIL %s timeout: no length block after %0d cycles", name, cyc);
      end
      idle_inputs();
      #1;
      vec_count++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         miscompare_count++;
         $display("[TB] FAIL %s done_pulse: done=%b busy=%b expected 1/0", name, done, busy);
      end
      vec_count++;
      if (aad_bytes !== 64'(aad_tot) || pld_bytes !== 64'(pld_tot) || err !== 1'b0) begin
         miscompare_count++;
         $display("[TB] FAIL %s counts: aad=%0d pld=%0d err=%b expected %0d/%0d/0",
                  name, aad_bytes, pld_bytes, err, aad_tot, pld_tot);
      end
      @(negedge clk); #1;
      vec_count++;
      if (done !== 1'b0) begin
         miscompare_count++;
         $display("[TB] FAIL %s done_width: done=%b expected 0", name, done);
      end
      aad_beats.delete(); aad_lens.delete(); pld_beats.delete(); pld_lens.delete();
   endtask

   task automatic test_reset();
      idle_inputs();
      start_o1 = 1'b0; start_o0 = 1'b0; ovf_aad_skip = 1'b1; ovf_pld_skip = 1'b0;
      bus_o1.s_aad_valid = 1'b0; bus_o1.s_aad_data = '0; bus_o1.s_aad_keep = '0; bus_o1.s_aad_last = 1'b0;
      bus_o0.s_aad_valid = 1'b0; bus_o0.s_aad_data = '0; bus_o0.s_aad_keep = '0; bus_o0.s_aad_last = 1'b0;
      bus_o1.s_pld_valid = 1'b0; bus_o1.s_pld_data = '0; bus_o1.s_pld_keep = '0; bus_o1.s_pld_last = 1'b0;
      bus_o0.s_pld_valid = 1'b0; bus_o0.s_pld_data = '0; bus_o0.s_pld_keep = '0; bus_o0.s_pld_last = 1'b0;
      bus_o1.aad_ready = 1'b1; bus_o1.pld_ready = 1'b1; bus_o1.len_ready = 1'b1;
      bus_o0.aad_ready = 1'b1; bus_o0.pld_ready = 1'b1; bus_o0.len_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vec_count++;
      if ({busy, done, err} !== 3'b000) begin
         miscompare_count++;
         $display("[TB] FAIL reset_status: busy/done/err=%b expected 000", {busy, done, err});
      end
      vec_count++;
      if ({bus.aad_valid, bus.pld_valid, bus.len_valid, bus.s_aad_ready, bus.s_pld_ready} !== 5'b0) begin
         miscompare_count++;
         $display("[TB] FAIL reset_valids: got %b expected 00000",
                  {bus.aad_valid, bus.pld_valid, bus.len_valid, bus.s_aad_ready, bus.s_pld_ready});
      end
      vec_count++;
      if (aad_bytes !== 64'd0 || pld_bytes !== 64'd0 || bus.len_block !== 128'd0 ||
          bus.aad_data !== 128'd0 || bus.pld_data !== 128'd0) begin
         miscompare_count++;
         $display("[TB] FAIL reset_data: aad=%0d pld=%0d len=%h expected zeros", aad_bytes, pld_bytes, bus.len_block);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      aad_beats.push_back(rand128()); aad_lens.push_back(16);
      aad_beats.push_back(rand128()); aad_lens.push_back(8);
      pld_beats.push_back(rand128()); pld_lens.push_back(16);
      run_message("directed", 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_skip_both();
      run_message("skip_both", 1'b1, 1'b1, 0, 1'b0);
   endtask

   task automatic test_stall();
      add_beats(1'b0, 3, 16);
      add_beats(1'b1, 3, $urandom_range(1, 16));
      run_message("stall", 1'b0, 1'b0, 5, 1'b0);
   endtask

   task automatic test_random();
      bit a_sk, p_sk;
      for (int m = 0; m < 12; m++) begin
         a_sk = ($urandom_range(0, 3) == 0);
         p_sk = ($urandom_range(0, 3) == 0);
         if (!a_sk) add_beats(1'b0, $urandom_range(1, 4), $urandom_range(1, 16));
         if (!p_sk) add_beats(1'b1, $urandom_range(1, 4), $urandom_range(1, 16));
         run_message("random", a_sk, p_sk, 0, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      add_beats(1'b0, 1, 5);
      add_beats(1'b1, 2, 16);
      run_message("b2b_first", 1'b0, 1'b0, 0, 1'b0);
      add_beats(1'b1, 1, 1);
      run_message("b2b_second", 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_bad_keep();
      logic [15:0] bad_last[4];
      bad_last[0] = 16'h0000; bad_last[1] = 16'h00F0; bad_last[2] = 16'h8001; bad_last[3] = 16'h0005;
      @(negedge clk); start = 1'b1; aad_skip = 1'b0; pld_skip = 1'b0;
      @(negedge clk); start = 1'b0;
      bus.s_aad_valid = 1'b1; bus.s_aad_data = rand128(); bus.s_aad_keep = 16'h7FFF; bus.s_aad_last = 1'b0;
      bus.aad_ready = 1'b1;
      #1;
      vec_count++;
      if (bus.s_aad_ready !== 1'b1) begin
         miscompare_count++;
         $display("[TB] FAIL bad_keep_ready: s_aad_ready=%b expected 1", bus.s_aad_ready);
      end
      @(negedge clk); bus.s_aad_valid = 1'b0; #1;
      vec_count++;
      if (err !== 1'b1 || busy !== 1'b0 || bus.aad_valid !== 1'b0 || aad_bytes !== 64'd0) begin
         miscompare_count++;
         $display("[TB] FAIL bad_keep_abort: err=%b busy=%b aad_valid=%b aad_bytes=%0d expected 1/0/0/0",
                  err, busy, bus.aad_valid, aad_bytes);
      end
      repeat (4) begin
         @(negedge clk); #1;
         vec_count++;
         if (done !== 1'b0 || bus.aad_valid !== 1'b0) begin
            miscompare_count++;
            $display("[TB] FAIL bad_keep_quiet: done=%b aad_valid=%b expected 0/0", done, bus.aad_valid);
         end
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      bus.s_aad_valid = 1'b1; bus.s_aad_data = rand128(); bus.s_aad_keep = 16'hFFFF; bus.s_aad_last = 1'b1;
      bus.aad_ready = 1'b0;
      #1;
      vec_count++;
      if (err !== 1'b0) begin
         miscompare_count++;
         $display("[TB] FAIL err_clear: err=%b expected 0", err);
      end
      @(negedge clk);
      bus.s_aad_valid = 1'b0;
      bus.s_pld_valid = 1'b1; bus.s_pld_data = rand128(); bus.s_pld_last = 1'b1;
      bus.s_pld_keep = bad_last[$urandom_range(0, 3)];
      bus.pld_ready = 1'b1;
      #1;
      vec_count++;
      if (bus.aad_valid !== 1'b1 || bus.s_pld_ready !== 1'b1) begin
         miscompare_count++;
         $display("[TB] FAIL discard_setup: aad_valid=%b s_pld_ready=%b expected 1/1", bus.aad_valid, bus.s_pld_ready);
      end
      @(negedge clk); bus.s_pld_valid = 1'b0; #1;
      vec_count++;
      if (err !== 1'b1 || busy !== 1'b0 || bus.aad_valid !== 1'b0 || bus.pld_valid !== 1'b0 || pld_bytes !== 64'd0) begin
         miscompare_count++;
         $display("[TB] FAIL discard: err=%b busy=%b aad_valid=%b pld_valid=%b pld_bytes=%0d expected 1/0/0/0/0",
                  err, busy, bus.aad_valid, bus.pld_valid, pld_bytes);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk); start = 1'b1; aad_skip = 1'b1; pld_skip = 1'b0;
      @(negedge clk); start = 1'b0;
      bus.s_pld_valid = 1'b1; bus.s_pld_data = rand128(); bus.s_pld_keep = 16'hFFFF; bus.s_pld_last = 1'b0;
      bus.pld_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vec_count++;
      if (bus.pld_valid !== 1'b1 || busy !== 1'b1 || pld_bytes !== 64'd16) begin
         miscompare_count++;
         $display("[TB] FAIL mid_setup: pld_valid=%b busy=%b pld_bytes=%0d expected 1/1/16", bus.pld_valid, busy, pld_bytes);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; bus.s_pld_valid = 1'b0; bus.pld_ready = 1'b1; bus.len_ready = 1'b1;
      #1;
      vec_count++;
      if ({busy, done, err, bus.pld_valid, bus.len_valid} !== 5'b0 || pld_bytes !== 64'd0 || bus.pld_data !== 128'd0) begin
         miscompare_count++;
         $display("[TB] FAIL mid_reset: busy/done/err/pld_valid/len_valid=%b pld_bytes=%0d expected zeros",
                  {busy, done, err, bus.pld_valid, bus.len_valid}, pld_bytes);
      end
      repeat (4) begin
         @(negedge clk); #1;
         vec_count++;
         if (bus.pld_valid !== 1'b0 || bus.len_valid !== 1'b0 || done !== 1'b0) begin
            miscompare_count++;
            $display("[TB] FAIL mid_quiet: pld_valid=%b len_valid=%b done=%b expected 0", bus.pld_valid, bus.len_valid, done);
         end
      end
      idle_inputs();
      add_beats(1'b0, 2, $urandom_range(1, 16));
      add_beats(1'b1, 2, $urandom_range(1, 16));
      run_message("after_reset", 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_overflow();
      int lim, nbeats, acc, outs, cyc, exp_first_bad;
      bit seen;
      lim = 1 << 8;
      nbeats = 17;
      // Wrapping instance: every beat lands, total is taken modulo 2^8.
      acc = 0; outs = 0; cyc = 0; seen = 0;
      @(negedge clk); start_o0 = 1'b1;
      @(negedge clk); start_o0 = 1'b0;
      while (!seen && cyc < 200) begin
         bus_o0.s_pld_valid = (acc < nbeats);
         bus_o0.s_pld_data = rand128(); bus_o0.s_pld_keep = 16'hFFFF; bus_o0.s_pld_last = (acc == nbeats - 1);
         #1;
         if (bus_o0.pld_valid && bus_o0.pld_ready) outs++;
         if (bus_o0.s_pld_valid && bus_o0.s_pld_ready) acc++;
         if (bus_o0.len_valid && bus_o0.len_ready) begin
            seen = 1;
            vec_count++;
            if (bus_o0.len_block !== {64'((nbeats * 16) % lim), 64'd0}) begin
               miscompare_count++;
               $display("[TB] FAIL wrap_len: got %h expected pld %0d", bus_o0.len_block, (nbeats * 16) % lim);
            end
         end
         @(negedge clk); cyc++;
      end
      bus_o0.s_pld_valid = 1'b0; #1;
      vec_count++;
      if (!seen || done_o0 !== 1'b1 || err_o0 !== 1'b0 || pld_bytes_o0 !== 8'((nbeats * 16) % lim) || outs != nbeats) begin
         miscompare_count++;
         $display("[TB] FAIL wrap_end: seen=%0d done=%b err=%b pld_bytes=%0d outs=%0d expected 1/1/0/%0d/%0d",
                  seen, done_o0, err_o0, pld_bytes_o0, outs, (nbeats * 16) % lim, nbeats);
      end
      // Erroring instance: the beat that reaches 256 bytes is dropped with err.
      exp_first_bad = (lim + 15) / 16;
      acc = 0; outs = 0; cyc = 0;
      @(negedge clk); start_o1 = 1'b1;
      @(negedge clk); start_o1 = 1'b0;
      while (busy_o1 && cyc < 200) begin
         bus_o1.s_pld_valid = (acc < nbeats);
         bus_o1.s_pld_data = rand128(); bus_o1.s_pld_keep = 16'hFFFF; bus_o1.s_pld_last = (acc == nbeats - 1);
         #1;
         if (bus_o1.pld_valid && bus_o1.pld_ready) outs++;
         if (bus_o1.s_pld_valid && bus_o1.s_pld_ready) acc++;
         @(negedge clk); cyc++;
      end
      bus_o1.s_pld_valid = 1'b0; #1;
      vec_count++;
      if (err_o1 !== 1'b1 || busy_o1 !== 1'b0 || acc != exp_first_bad || outs != exp_first_bad - 1 ||
          pld_bytes_o1 !== 8'((exp_first_bad - 1) * 16)) begin
         miscompare_count++;
         $display("[TB] FAIL ovf_err: err=%b busy=%b accepted=%0d outs=%0d pld_bytes=%0d expected 1/0/%0d/%0d/%0d",
                  err_o1, busy_o1, acc, outs, pld_bytes_o1, exp_first_bad, exp_first_bad - 1, (exp_first_bad - 1) * 16);
      end
      repeat (3) begin
         @(negedge clk); #1;
         vec_count++;
         if (done_o1 !== 1'b0 || bus_o1.len_valid !== 1'b0) begin
            miscompare_count++;
            $display("[TB] FAIL ovf_quiet: done=%b len_valid=%b expected 0/0", done_o1, bus_o1.len_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_skip_both();
      test_stall();
      test_bad_keep();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
      $finish;
   end

endmodule

// File: doc/chacha_aead_framer.md
CHACHA_AEAD_FRAMER -- requirements
Module: chacha_aead_framer

Interface
REQ-001 SHALL have parameter LEN_W, default 64, range 8..64; width of the AAD and payload byte counters.
REQ-002 SHALL have parameter ERR_ON_OVF, default 1; 1 = counter overflow raises error, 0 = counter wraps silently.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  begin a message; sampled only in IDLE.
REQ-006 aad_skip, pld_skip  in  1 each  message has no AAD / no payload; sampled with start.
REQ-007 s_aad_valid, s_aad_data[127:0], s_aad_keep[15:0], s_aad_last  in; s_aad_ready  out  AAD input stream; byte i = data[8i+7:8i].
REQ-008 s_pld_valid, s_pld_data[127:0], s_pld_keep[15:0], s_pld_last  in; s_pld_ready  out  payload (ciphertext) input stream.
REQ-009 aad_valid, aad_data[127:0], aad_keep[15:0]  out; aad_ready  in  padded AAD blocks to core.
REQ-010 pld_valid, pld_data[127:0], pld_keep[15:0]  out; pld_ready  in  padded payload blocks to core.
REQ-011 len_valid, len_block[127:0]  out; len_ready  in  Poly1305 length block to core.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle pulse when the length block is accepted.
REQ-014 err  out  1  sticky error flag; cleared on accepted start.
REQ-015 aad_bytes[LEN_W-1:0], pld_bytes[LEN_W-1:0]  out  running byte counts.

Function
REQ-016 SHALL implement states IDLE, AAD, PLD, LEN; encoding is free.
REQ-017 IDLE + start: clear counters and err; next state AAD, or PLD if aad_skip, or LEN if both skips set.
REQ-018 AAD: a beat transfers on s_aad_valid && s_aad_ready; a beat carrying s_aad_last moves the FSM to PLD, or to LEN if pld_skip.
REQ-019 PLD: a beat carrying s_pld_last moves the FSM to LEN.
REQ-020 LEN: drives len_valid; on len_valid && len_ready, pulse done next cycle and return to IDLE.
REQ-021 Each output stream SHALL be a one-entry register: s_x_ready = (state==X) && (!x_valid || x_ready); output valid one cycle after input acceptance; full throughput of 1 beat/cycle.
REQ-022 Output data SHALL zero bytes whose keep bit is 0 (pad16); output keep SHALL always be 16'hFFFF.
REQ-023 Counter SHALL add popcount(keep) per accepted beat, modulo 2^LEN_W.
REQ-024 Valid keep: non-last beat requires 16'hFFFF; last beat requires contiguous ones from bit 0, 1..16 bytes.
REQ-025 Invalid keep: set err, drop the beat (no output, no count), return to IDLE at the next edge; outstanding output register is discarded.
REQ-026 ERR_ON_OVF=1 and counter carry-out: same as REQ-025.
REQ-027 len_block[63:0] = aad_bytes zero-extended to 64 bits; len_block[127:64] = pld_bytes zero-extended.
REQ-028 LEN entered only after both output registers are empty; len_valid asserts the cycle after that condition holds.
REQ-029 Output valid SHALL hold with stable data until ready; start outside IDLE is ignored.
REQ-030 Streams not in the current state SHALL see ready=0.

Reset
REQ-031 rst_n low at an edge: state IDLE; all valids, busy, done, err 0; counters 0; data registers 0.
REQ-032 Reset mid-message SHALL abort without emitting further beats or done.

Verification
REQ-033 start, 2 AAD beats (keep FFFF, then 00FF last), 1 payload beat FFFF last -> AAD out 2nd beat upper 8 bytes zero; len_block = {64'd16, 64'd24}; done pulse once.
REQ-034 start with aad_skip=1, pld_skip=1 -> no AAD/payload beats; len_block = 0; done after len_ready.
REQ-035 AAD non-last beat keep 16'h7FFF -> err=1, FFSM IDLE, no aad_valid for that beat, no done.
REQ-036 aad_ready/pld_ready held 0 for 5 cycles with valid inputs -> no beat lost or duplicated; s_x_ready low while register full.
REQ-037 LEN_W=8, 17 payload beats FFFF -> overflow at 256 bytes: err=1 with ERR_ON_OVF=1; ERR_ON_OVF=0 -> pld_bytes = 16, done.
REQ-038 rst_n low 1 cycle during PLD -> all outputs at reset values next cycle; subsequent message completes normally.
